wb_itr_chk: RTL and testbench

WB_ITR_CHK -- requirements
Module: wb_itr_chk

---
 rtl/wb_itr_chk.sv | 144 ++++++++++++++
 tb/tb_wb_itr_chk.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_itr_chk.sv
// Passive Wishbone pipelined initiator-port protocol checker.
// Optional statistics counters: define WB_ITR_CHK_STATS_EN.
module wb_itr_chk #(
   parameter int ADR_WIDTH = 16,
   parameter int SEL_WIDTH = 2,
   parameter int MAX_OUT   = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk_i,
   input  logic                 async_rst_i,
   input  logic                 sync_rst_i,
   input  logic                 itr_cyc_i,
   input  logic                 itr_stb_i,
   input  logic                 itr_we_i,
   input  logic [ADR_WIDTH-1:0] itr_adr_i,
   input  logic [SEL_WIDTH-1:0] itr_sel_i,
   input  logic                 itr_ack_o,
   input  logic                 itr_err_o,
   input  logic                 itr_rty_o,
   input  logic                 itr_stall_o,
   input  logic                 mon_err_clr_i,
   output logic [7:0]           mon_out_o,
   output logic                 mon_busy_o,
   output logic [4:0]           mon_err_o,
   output logic                 mon_irq_o,
   output logic [31:0]          mon_req_cnt_o,
   output logic [31:0]          mon_term_cnt_o
);

   typedef enum logic [1:0] {
      S_RESET,
      S_IDLE,
      S_BUSY
   } state_e;

   localparam logic [7:0]  MAX_C   = 8'(MAX_OUT);
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] wd_q, wd_d;
   logic [4:0]  err_q, err_d, err_new;
   logic        irq_q;

   logic req, term, multi, live, wd_run;
   logic unused_obs;

   // Address, select and direction are observed but do not affect checks.
   assign unused_obs = ^{itr_we_i, itr_adr_i, itr_sel_i};

   assign req   = itr_cyc_i & itr_stb_i & ~itr_stall_o;
   assign term  = itr_ack_o | itr_err_o | itr_rty_o;
   assign multi = (itr_ack_o & itr_err_o) | (itr_ack_o & itr_rty_o)
                | (itr_err_o & itr_rty_o);
   assign live  = (state_q != S_RESET);
   assign wd_run = ((cnt_q != 8'd0) | (itr_cyc_i & itr_stb_i & itr_stall_o))
                 & ~req & ~term;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wd_d    = '0;
      err_new = '0;
      if (live) begin
         err_new[0] = multi;
         err_new[1] = term & (cnt_q == 8'd0);
         if (!itr_cyc_i && cnt_q != 8'd0) begin
            err_new[3] = 1'b1;
            cnt_d      = '0;
         end else if (req && !term) begin
            if (cnt_q == MAX_C) err_new[2] = 1'b1;
            else                cnt_d = cnt_q + 8'd1;
         end else if (term && !req && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
         end
         if (wd_run) begin
            wd_d       = (wd_q == TMO_LIM) ? wd_q : wd_q + 16'd1;
            err_new[4] = (wd_d == TMO_LIM);
         end
      end
      unique case (state_q)
         S_RESET: begin
            state_d    = S_IDLE;
            err_new[4] = itr_cyc_i | itr_stb_i;
         end
         S_IDLE: if (req) state_d = S_BUSY;
         S_BUSY: if (cnt_d == 8'd0 && !req) state_d = S_IDLE;
         default: state_d = S_RESET;
      endcase
      // A flag raised in the clearing cycle must not be lost.
      err_d = (err_q & ~{5{mon_err_clr_i}}) | err_new;
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
         wd_q    <= '0;
         err_q   <= '0;
         irq_q   <= 1'b0;
      end else if (sync_rst_i) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
         wd_q    <= '0;
         err_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         irq_q   <= |err_q;
      end
   end

   assign mon_out_o  = cnt_q;
   assign mon_busy_o = (state_q == S_BUSY);
   assign mon_err_o  = err_q;
   assign mon_irq_o  = irq_q;

`ifdef WB_ITR_CHK_STATS_EN
   logic [31:0] req_cnt_q, term_cnt_q;

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         req_cnt_q  <= '0;
         term_cnt_q <= '0;
      end else if (sync_rst_i) begin
         req_cnt_q  <= '0;
         term_cnt_q <= '0;
      end else begin
         req_cnt_q  <= req_cnt_q + 32'(req);
         term_cnt_q <= term_cnt_q + 32'(term);
      end
   end

   assign mon_req_cnt_o  = req_cnt_q;
   assign mon_term_cnt_o = term_cnt_q;
`else
   assign mon_req_cnt_o  = '0;
   assign mon_term_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_itr_chk.sv
// Directed scoreboard bench for wb_itr_chk (MAX_OUT=4, TIMEOUT=8).
// Stats wrap check runs when WB_ITR_CHK_STATS_EN is defined.
module tb_wb_itr_chk;

   logic        clk_i = 1'b0;
   logic        async_rst_i = 1'b1;
   logic        sync_rst_i = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [15:0] adr = '0;
   logic [1:0]  sel = '0;
   logic        ack = 1'b0, err = 1'b0, rty = 1'b0, stall = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  mon_out;
   logic        mon_busy;
   logic [4:0]  mon_err;
   logic        mon_irq;
   logic [31:0] req_cnt, term_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [7:0] o;
      logic       b;
      logic [4:0] e;
      logic       irq;
   } exp_t;

   exp_t       sb[$];
   logic [4:0] prev_e = '0;

   wb_itr_chk #(
      .ADR_WIDTH(16),
      .SEL_WIDTH(2),
      .MAX_OUT(4),
      .TIMEOUT(8)
   ) dut (
      .clk_i(clk_i),
      .async_rst_i(async_rst_i),
      .sync_rst_i(sync_rst_i),
      .itr_cyc_i(cyc),
      .itr_stb_i(stb),
      .itr_we_i(we),
      .itr_adr_i(adr),
      .itr_sel_i(sel),
      .itr_ack_o(ack),
      .itr_err_o(err),
      .itr_rty_o(rty),
      .itr_stall_o(stall),
      .mon_err_clr_i(clr),
      .mon_out_o(mon_out),
      .mon_busy_o(mon_busy),
      .mon_err_o(mon_err),
      .mon_irq_o(mon_irq),
      .mon_req_cnt_o(req_cnt),
      .mon_term_cnt_o(term_cnt)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of bus activity, push its expected result,
   // then pop and compare just after the clock edge.
   task automatic step(input string tag,
                       input logic c, input logic s, input logic sl,
                       input logic a, input logic e, input logic r,
                       input logic cl, input logic sr,
                       input logic [7:0] o, input logic b,
                       input logic [4:0] er);
      exp_t x;
      cyc = c; stb = s; stall = sl;
      ack = a; err = e; rty = r;
      clr = cl; sync_rst_i = sr;
      we = $urandom_range(0, 1);
      adr = 16'($urandom);
      sel = 2'($urandom);
      x.tag = tag; x.o = o; x.b = b; x.e = er; x.irq = |prev_e;
      sb.push_back(x);
      prev_e = er;
      @(posedge clk_i);
      #1;
      x = sb.pop_front();
      chk({x.tag, ".out"}, 32'(mon_out), 32'(x.o));
      chk({x.tag, ".busy"}, 32'(mon_busy), 32'(x.b));
      chk({x.tag, ".err"}, 32'(mon_err), 32'(x.e));
      chk({x.tag, ".irq"}, 32'(mon_irq), 32'(x.irq));
   endtask

   initial begin
      #2;
      chk("rst.out", 32'(mon_out), 32'd0);
      chk("rst.busy", 32'(mon_busy), 32'd0);
      chk("rst.err", 32'(mon_err), 32'd0);
      chk("rst.irq", 32'(mon_irq), 32'd0);
      @(posedge clk_i);
      #1 async_rst_i = 1'b0;
      step("boot", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b00000);

      // three back-to-back requests, then three acks
      step("b2b_r0", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("b2b_r1", 1,1,0, 0,0,0, 0,0, 2, 1, 5'b00000);
      step("b2b_r2", 1,1,0, 0,0,0, 0,0, 3, 1, 5'b00000);
      step("b2b_a0", 1,0,0, 1,0,0, 0,0, 2, 1, 5'b00000);
      step("b2b_a1", 1,0,0, 1,0,0, 0,0, 1, 1, 5'b00000);
      step("b2b_a2", 1,0,0, 1,0,0, 0,0, 0, 0, 5'b00000);
      step("b2b_end", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b00000);

      // overflow at MAX_OUT
      step("ovf_r0", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("ovf_r1", 1,1,0, 0,0,0, 0,0, 2, 1, 5'b00000);
      step("ovf_r2", 1,1,0, 0,0,0, 0,0, 3, 1, 5'b00000);
      step("ovf_r3", 1,1,0, 0,0,0, 0,0, 4, 1, 5'b00000);
      step("ovf_r4", 1,1,0, 0,0,0, 0,0, 4, 1, 5'b00100);
      step("ovf_clr", 1,0,0, 1,0,0, 1,0, 3, 1, 5'b00000);
      step("ovf_a1", 1,0,0, 1,0,0, 0,0, 2, 1, 5'b00000);
      step("ovf_a2", 1,0,0, 1,0,0, 0,0, 1, 1, 5'b00000);
      step("ovf_a3", 1,0,0, 1,0,0, 0,0, 0, 0, 5'b00000);
      step("ovf_end", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b00000);

      // multiple and unsolicited terminations
      step("mt_req", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("mt_ae", 1,0,0, 1,1,0, 0,0, 0, 0, 5'b00001);
      step("mt_clr", 0,0,0, 0,0,0, 1,0, 0, 0, 5'b00000);
      step("us_ack", 1,0,0, 1,0,0, 0,0, 0, 0, 5'b00010);
      step("us_clr", 0,0,0, 0,0,0, 1,0, 0, 0, 5'b00000);
      step("us_end", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b00000);

      // watchdog: flag exactly 7 cycles after the last request
      step("wd_req", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      for (int i = 1; i <= 6; i++)
         step($sformatf("wd_w%0d", i), 1,0,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("wd_hit", 1,0,0, 0,0,0, 0,0, 1, 1, 5'b10000);
      step("wd_hold", 1,0,0, 0,0,0, 0,0, 1, 1, 5'b10000);
      step("wd_drop", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b11000);
      step("wd_clr", 0,0,0, 0,0,0, 1,0, 0, 0, 5'b00000);

      // cyc dropped with two outstanding
      step("cd_r0", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("cd_r1", 1,1,0, 0,0,0, 0,0, 2, 1, 5'b00000);
      step("cd_drop", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b01000);
      step("cd_clr", 0,0,0, 0,0,0, 1,0, 0, 0, 5'b00000);

      // async reset with three outstanding
      step("ar_r0", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("ar_r1", 1,1,0, 0,0,0, 0,0, 2, 1, 5'b00000);
      step("ar_r2", 1,1,0, 0,0,0, 0,0, 3, 1, 5'b00000);
      cyc = 1'b0; stb = 1'b0;
      #2 async_rst_i = 1'b1;
      #1;
      chk("ar.out", 32'(mon_out), 32'd0);
      chk("ar.busy", 32'(mon_busy), 32'd0);
      chk("ar.err", 32'(mon_err), 32'd0);
      chk("ar.irq", 32'(mon_irq), 32'd0);
      #2 async_rst_i = 1'b0;
      prev_e = '0;
      step("ar_post", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b00000);

      // clear concurrent with a new MULTI_TERM
      step("mc_req", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("mc_ae", 1,0,0, 1,1,0, 0,0, 0, 0, 5'b00001);
      step("mc_ar", 1,0,0, 1,0,1, 1,0, 0, 0, 5'b00011);
      step("mc_clr", 0,0,0, 0,0,0, 1,0, 0, 0, 5'b00000);
      step("mc_end", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b00000);

      // sync reset mid-transaction, then illegal bus out of reset
      step("sr_req", 1,1,0, 0,0,0, 0,0, 1, 1, 5'b00000);
      step("sr_rst", 1,1,0, 0,0,0, 0,1, 0, 0, 5'b00000);
      step("sr_cyc", 1,0,0, 0,0,0, 0,0, 0, 0, 5'b10000);
      step("sr_clr", 0,0,0, 0,0,0, 1,0, 0, 0, 5'b00000);
      step("sr_end", 0,0,0, 0,0,0, 0,0, 0, 0, 5'b00000);

`ifdef WB_ITR_CHK_STATS_EN
      @(negedge clk_i);
      force dut.req_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.req_cnt_q;
      cyc = 1'b1; stb = 1'b1;
      @(posedge clk_i);
      #1;
      cyc = 1'b0; stb = 1'b0;
      chk("stats.wrap", req_cnt, 32'd0);
`else
      chk("stats.req0", req_cnt, 32'd0);
      chk("stats.term0", term_cnt, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
